// File: rtl/datapath_arbiter_pkg.sv
// rtl/datapath_arbiter_pkg.sv - shared datapath widths, opcodes and arbiter state encoding
package datapath_arbiter_pkg;

   localparam int DP_INSTRUCTION_WIDTH = 32;
   localparam int DP_RESULT_WIDTH      = 32;
   localparam int DP_TIMEOUT_DEFAULT   = 1024;

   localparam logic [7:0] OP_DRAW     = 8'd1;
   localparam logic [7:0] OP_MEM_READ = 8'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DONE   = 3'd4
   } arb_state_e;

endpackage

// File: rtl/datapath_arbiter_rr_priority_picker.sv
// rtl/datapath_arbiter_rr_priority_picker.sv - first set request at or after a rotating pointer
module datapath_arbiter_rr_priority_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               found,
   output logic [IDX_W-1:0]   winner
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [IDX_W:0]       idx_sum;

   assign req_dbl = {req, req};
   assign req_rot = NUM_REQ'(req_dbl >> ptr);

   // Scanning from the far offset down leaves the offset nearest ptr as the final winner.
   always_comb begin
      found   = 1'b0;
      winner  = '0;
      idx_sum = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            found   = 1'b1;
            idx_sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (idx_sum >= (IDX_W+1)'(NUM_REQ))
               idx_sum = idx_sum - (IDX_W+1)'(NUM_REQ);
            winner  = idx_sum[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/datapath_arbiter.sv
// rtl/datapath_arbiter.sv - round-robin sharing of one datapath among NUM_REQ requesters
module datapath_arbiter
   import datapath_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int INSTR_WIDTH    = DP_INSTRUCTION_WIDTH,
   parameter int RESULT_WIDTH   = DP_RESULT_WIDTH,
   parameter int TIMEOUT_CYCLES = DP_TIMEOUT_DEFAULT
) (
   input  logic                           clock,
   input  logic                           resetn,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*INSTR_WIDTH-1:0] req_instruction,
   output logic [NUM_REQ-1:0]             req_done,
   output logic [RESULT_WIDTH-1:0]        req_result,
   output logic                           req_error,
   output logic                           busy,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id,
   output logic                           start_dp,
   output logic [INSTR_WIDTH-1:0]         instruction_dp,
   input  logic                           finished_dp,
   input  logic [RESULT_WIDTH-1:0]        result_dp
);

   localparam int GW       = $clog2(NUM_REQ);
   localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   arb_state_e             state;
   logic [GW-1:0]          rr_ptr;
   logic [CNT_W-1:0]       tmo_cnt;
   logic                   pick_found;
   logic [GW-1:0]          pick_idx;
   logic [INSTR_WIDTH-1:0] pick_instr;

   datapath_arbiter_rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (GW)
   ) u_picker (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .found  (pick_found),
      .winner (pick_idx)
   );

   always_comb begin
      pick_instr = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pick_idx == GW'(i))
            pick_instr = req_instruction[i*INSTR_WIDTH +: INSTR_WIDTH];
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state          <= ST_IDLE;
         rr_ptr         <= '0;
         tmo_cnt        <= '0;
         grant_id       <= '0;
         instruction_dp <= '0;
         start_dp       <= 1'b0;
         req_done       <= '0;
         req_result     <= '0;
         req_error      <= 1'b0;
         busy           <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  grant_id       <= pick_idx;
                  instruction_dp <= pick_instr;
                  start_dp       <= 1'b1;
                  busy           <= 1'b1;
                  state          <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               start_dp <= 1'b0;
               state    <= ST_SETTLE;
            end
            // finished_dp still shows the previous idle level here, so it is not looked at.
            ST_SETTLE: begin
               tmo_cnt <= '0;
               state   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (finished_dp) begin
                  req_result <= result_dp;
                  req_error  <= 1'b0;
                  req_done   <= NUM_REQ'(1) << grant_id;
                  state      <= ST_DONE;
               end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_W'(TMO_LAST))) begin
                  req_result <= '0;
                  req_error  <= 1'b1;
                  req_done   <= NUM_REQ'(1) << grant_id;
                  state      <= ST_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               req_done  <= '0;
               req_error <= 1'b0;
               busy      <= 1'b0;
               rr_ptr    <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_datapath_arbiter.sv
// tb/tb_datapath_arbiter.sv - randomized and directed checks of datapath_arbiter against a timeline model
module tb_datapath_arbiter;

   localparam int N   = 4;
   localparam int IW  = 32;
   localparam int RW  = 32;
   localparam int TMO = 8;

   logic            clock = 1'b0;
   logic            resetn;
   logic [N-1:0]    req_valid;
   logic [N*IW-1:0] req_instruction;
   logic [N-1:0]    req_done;
   logic [RW-1:0]   req_result;
   logic            req_error;
   logic            busy;
   logic [1:0]      grant_id;
   logic            start_dp;
   logic [IW-1:0]   instruction_dp;
   logic            finished_dp;
   logic [RW-1:0]   result_dp;

   datapath_arbiter #(
      .NUM_REQ        (N),
      .INSTR_WIDTH    (IW),
      .RESULT_WIDTH   (RW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock           (clock),
      .resetn          (resetn),
      .req_valid       (req_valid),
      .req_instruction (req_instruction),
      .req_done        (req_done),
      .req_result      (req_result),
      .req_error       (req_error),
      .busy            (busy),
      .grant_id        (grant_id),
      .start_dp        (start_dp),
      .instruction_dp  (instruction_dp),
      .finished_dp     (finished_dp),
      .result_dp       (result_dp)
   );

   always #5 clock = ~clock;

   // requester side
   logic [N-1:0]  want;
   logic [IW-1:0] instr [N];
   bit            keep_high [N];
   int            force_k [N];
   bit            force_val_en [N];
   logic [RW-1:0] force_val [N];
   bit            rand_mode;

   // model: an operation is a timeline measured in cycles since its grant
   bit            m_active;
   int            m_age, m_gid, m_k, m_done_age, m_ptr, m_grants;
   bit            m_err;
   logic [RW-1:0] m_val, m_result;
   logic [IW-1:0] m_instr;

   // observations of the DUT for the literal checks
   int            dut_grants [$];
   logic [N-1:0]  done_vecs [$];
   logic [RW-1:0] done_res [$];
   logic          done_err [$];
   int            done_cyc [$];
   int            start_cnt;
   logic [IW-1:0] start_instr;

   int n_cmp, n_fail, cyc, t0;
   int exp_order [5];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
      end
   endtask

   task automatic bound_chk(input string name, input bit expired);
      n_cmp++;
      if (expired) begin
         n_fail++;
         $display("FAIL %s cycle %0d: wait bound expired", name, cyc);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0; m_age = 0; m_ptr = 0; m_gid = 0;
      m_instr = '0; m_result = '0;
   endtask

   task automatic model_advance();
      int idx;
      if (m_active) begin
         if (m_age == m_done_age) begin
            m_active = 1'b0;
            m_ptr    = (m_gid + 1) % N;
         end else begin
            m_age++;
            if (m_age == m_done_age) m_result = m_err ? '0 : m_val;
         end
      end else begin
         for (int o = 0; o < N; o++) begin
            idx = (m_ptr + o) % N;
            if (!m_active && want[idx]) begin
               m_active = 1'b1; m_age = 1; m_gid = idx; m_instr = instr[idx]; m_grants++;
               m_k = (force_k[idx] >= 0) ? force_k[idx] : (rand_mode ? int'($urandom_range(0, 10)) : 0);
               m_val = force_val_en[idx] ? force_val[idx] : RW'($urandom);
               m_err = (m_k >= TMO);
               m_done_age = 4 + (m_err ? TMO - 1 : m_k);
            end
         end
      end
   endtask

   task automatic apply_reqs();
      req_valid = want;
      for (int i = 0; i < N; i++) req_instruction[i*IW +: IW] = instr[i];
   endtask

   task automatic compare_all();
      logic [N-1:0] e_done;
      e_done = (m_active && m_age == m_done_age) ? (N'(1) << m_gid) : '0;
      chk("busy",           32'(busy),      32'(m_active));
      chk("start_dp",       32'(start_dp),  32'(m_active && m_age == 1));
      chk("instruction_dp", instruction_dp, m_instr);
      chk("grant_id",       32'(grant_id),  32'(m_gid));
      chk("req_done",       32'(req_done),  32'(e_done));
      chk("req_error",      32'(req_error), 32'(m_active && m_age == m_done_age && m_err));
      chk("req_result",     req_result,     m_result);
      if (start_dp) begin
         start_cnt++;
         start_instr = instruction_dp;
         dut_grants.push_back(int'(grant_id));
      end
      if (req_done != '0) begin
         done_vecs.push_back(req_done);
         done_res.push_back(req_result);
         done_err.push_back(req_error);
         done_cyc.push_back(cyc);
      end
   endtask

   task automatic drive_and_advance();
      if (m_active && m_age == m_done_age && !keep_high[m_gid]) want[m_gid] = 1'b0;
      if (rand_mode) begin
         for (int i = 0; i < N; i++) begin
            keep_high[i] = ($urandom_range(0, 7) == 0);
            if (!want[i] && !(m_active && m_gid == i) && $urandom_range(0, 3) == 0) begin
               want[i]  = 1'b1;
               instr[i] = IW'($urandom);
            end
         end
         if (m_active && m_age >= 2 && m_age < m_done_age && $urandom_range(0, 15) == 0) begin
            want[m_gid]  = 1'b0;
            instr[m_gid] = IW'($urandom);
         end
      end
      // datapath: stale idle level through ISSUE/SETTLE, then low for m_k WAIT cycles
      result_dp   = RW'($urandom);
      finished_dp = 1'b1;
      if (m_active && m_age >= 3) begin
         if (m_age - 3 < m_k) finished_dp = 1'b0;
         else                 result_dp   = m_val;
      end
      apply_reqs();
      model_advance();
   endtask

   task automatic step();
      @(negedge clock);
      cyc++;
      compare_all();
      drive_and_advance();
   endtask

   task automatic pulse_reset(input int hold);
      @(negedge clock);
      cyc++;
      resetn = 1'b0;
      #1;
      chk("rst_busy",     32'(busy),      32'(0));
      chk("rst_start",    32'(start_dp),  32'(0));
      chk("rst_instr",    instruction_dp, 32'(0));
      chk("rst_grant",    32'(grant_id),  32'(0));
      chk("rst_done",     32'(req_done),  32'(0));
      chk("rst_error",    32'(req_error), 32'(0));
      chk("rst_result",   req_result,     32'(0));
      model_reset();
      repeat (hold) begin
         @(negedge clock);
         cyc++;
         compare_all();
      end
      @(negedge clock);
      cyc++;
      resetn = 1'b1;
      compare_all();
      drive_and_advance();
   endtask

   task automatic run_until_idle(input int budget);
      int b;
      b = 0;
      while ((m_active || want != '0) && b < budget) begin
         step();
         b++;
      end
      bound_chk("drain", m_active || want != '0);
   endtask

   task automatic clear_obs();
      dut_grants.delete(); done_vecs.delete(); done_res.delete();
      done_err.delete(); done_cyc.delete();
      start_cnt = 0; start_instr = '0;
   endtask

   task automatic clear_forces();
      for (int i = 0; i < N; i++) begin
         force_k[i] = -1; force_val_en[i] = 1'b0; force_val[i] = '0; keep_high[i] = 1'b0;
      end
   endtask

   initial begin
      int b;
      n_cmp = 0; n_fail = 0; cyc = 0; rand_mode = 1'b0; m_grants = 0;
      resetn = 1'b0; want = '0; finished_dp = 1'b1; result_dp = '0;
      for (int i = 0; i < N; i++) instr[i] = '0;
      exp_order = '{0, 1, 2, 3, 0};
      clear_forces();
      apply_reqs();
      model_reset();
      pulse_reset(2);

      // single request, result arrives in the second WAIT cycle
      force_k[0] = 1; force_val_en[0] = 1'b1; force_val[0] = 32'h0000_0007;
      instr[0] = 32'h2000_0010; want = 4'b0001;
      clear_obs();
      t0 = cyc + 1;
      run_until_idle(50);
      chk("b_start_cnt",  32'(start_cnt),    32'd1);
      chk("b_start_inst", start_instr,       32'h2000_0010);
      chk("b_done_vec",   32'(done_vecs[0]), 32'b0001);
      chk("b_result",     done_res[0],       32'h0000_0007);
      chk("b_error",      32'(done_err[0]),  32'd0);
      chk("b_latency",    32'(done_cyc[0] - t0), 32'd5);

      // all four at once from reset, requester 0 keeps requesting once; finished held high
      clear_forces();
      for (int i = 0; i < N; i++) begin
         force_k[i] = 0; force_val_en[i] = 1'b1; force_val[i] = 32'hA0 + 32'(i);
         instr[i] = 32'h1000_0000 + 32'(i);
      end
      keep_high[0] = 1'b1; want = 4'b1111; m_grants = 0;
      clear_obs();
      pulse_reset(1);
      t0 = cyc;
      b = 0;
      while (m_grants < 5 && b < 100) begin step(); b++; end
      bound_chk("c_grants", m_grants < 5);
      keep_high[0] = 1'b0;
      run_until_idle(100);
      chk("c_done_cnt", 32'(done_vecs.size()), 32'd5);
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("c_grant%0d", j),  32'(dut_grants[j]), 32'(exp_order[j]));
         chk($sformatf("c_donev%0d", j),  32'(done_vecs[j]),  32'(1) << exp_order[j]);
         chk($sformatf("c_result%0d", j), done_res[j],        32'hA0 + 32'(exp_order[j]));
      end
      chk("c_latency", 32'(done_cyc[0] - t0), 32'd4);

      // timeout on requester 0, requester 1 served next
      clear_forces();
      force_k[0] = 100; force_val_en[0] = 1'b1; force_val[0] = 32'hDEAD_BEEF;
      force_k[1] = 0;   force_val_en[1] = 1'b1; force_val[1] = 32'h0000_5A5A;
      instr[0] = 32'h1000_0001; instr[1] = 32'h2000_0002; want = 4'b0011;
      clear_obs();
      pulse_reset(1);
      t0 = cyc;
      run_until_idle(100);
      chk("d_done_vec0", 32'(done_vecs[0]), 32'b0001);
      chk("d_error0",    32'(done_err[0]),  32'd1);
      chk("d_result0",   done_res[0],       32'd0);
      chk("d_latency",   32'(done_cyc[0] - t0), 32'd11);
      chk("d_grant1",    32'(dut_grants[1]), 32'd1);
      chk("d_error1",    32'(done_err[1]),  32'd0);
      chk("d_result1",   done_res[1],       32'h0000_5A5A);

      // reset during WAIT with requester 2 granted
      clear_forces();
      force_k[2] = 100; instr[2] = 32'h2000_0222; want = 4'b0100;
      pulse_reset(1);
      b = 0;
      while (!(m_active && m_age == 5) && b < 20) begin step(); b++; end
      bound_chk("e_reach_wait", !(m_active && m_age == 5));
      chk("e_gid_wait", 32'(grant_id), 32'd2);
      want[0] = 1'b1; instr[0] = 32'h1000_0000; force_k[2] = 0;
      clear_obs();
      pulse_reset(2);
      run_until_idle(100);
      chk("e_grant0",    32'(dut_grants[0]),    32'd0);
      chk("e_grant1",    32'(dut_grants[1]),    32'd2);
      chk("e_done_vec0", 32'(done_vecs[0]),     32'b0001);
      chk("e_done_cnt",  32'(done_vecs.size()), 32'd2);

      // requester 1 drops req_valid and changes its instruction while in WAIT
      clear_forces();
      force_k[1] = 3; instr[1] = 32'h2000_0044; want = 4'b0010;
      clear_obs();
      b = 0;
      while (!(m_active && m_age == 4) && b < 20) begin step(); b++; end
      bound_chk("f_reach_wait", !(m_active && m_age == 4));
      want[1] = 1'b0; instr[1] = 32'hFFFF_FFFF;
      run_until_idle(100);
      chk("f_done_cnt",   32'(done_vecs.size()), 32'd1);
      chk("f_done_vec",   32'(done_vecs[0]),     32'b0010);
      chk("f_start_cnt",  32'(start_cnt),        32'd1);
      chk("f_start_inst", start_instr,           32'h2000_0044);

      // randomized traffic
      clear_forces();
      rand_mode = 1'b1;
      repeat (3000) step();
      rand_mode = 1'b0;
      for (int i = 0; i < N; i++) keep_high[i] = 1'b0;
      run_until_idle(500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
